// File: rtl/op_state_sequencer.sv
// ---------------------------------------------------------------------------
// op_state_sequencer
//
// Purpose:
//   Frame-based operating-state sequencer for a panel driver. After reset it
//   runs an INIT waveform of INIT_FRAMES frames, then stays in NORMAL. It can
//   run an in-place clear (CLEAR_NORMAL, CLEAR_FRAMES frames) or a full
//   re-init on request. State and frame counter advance only on accepted
//   frame ticks (frame_tick while en), so both are stable for a whole frame.
//
// Parameters:
//   INIT_FRAMES   frame length of the power-up init waveform   (1..2047)
//   CLEAR_FRAMES  frame length of an in-place screen clear     (1..2047)
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   en             in   sequencer enable; 0 freezes state (requests still latch)
//   frame_tick     in   one-cycle pulse at each frame boundary
//   clear_req      in   one-cycle pulse requesting an in-place clear
//   reinit_req     in   one-cycle pulse requesting a full re-init
//   op_state       out  0=INIT, 1=NORMAL, 2=CLEAR_NORMAL (3 never driven)
//   op_framecount  out  frame index within the current state
//   op_commit      out  one-cycle pulse after every accepted tick
//   clear_done     out  one-cycle pulse when a clear completes
//   busy           out  state != NORMAL or a request is pending
// ---------------------------------------------------------------------------
module op_state_sequencer #(
  parameter logic [10:0] INIT_FRAMES  = 11'd340,
  parameter logic [10:0] CLEAR_FRAMES = 11'd120
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        frame_tick,
  input  logic        clear_req,
  input  logic        reinit_req,
  output logic [1:0]  op_state,
  output logic [10:0] op_framecount,
  output logic        op_commit,
  output logic        clear_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_NORMAL = 2'd1,
    ST_CLEAR  = 2'd2
  } op_state_e;

  localparam logic [10:0] COUNT_MAX  = 11'd2047;
  localparam logic [10:0] INIT_LAST  = INIT_FRAMES - 11'd1;
  localparam logic [10:0] CLEAR_LAST = CLEAR_FRAMES - 11'd1;

  op_state_e   state_q, state_d;
  logic [10:0] count_q, count_d;
  logic        commit_q, commit_d;
  logic        done_q, done_d;
  logic        clr_pend_q, clr_pend_d;
  logic        init_pend_q, init_pend_d;

  logic        tick_acc_s;
  logic        eff_reinit_s;
  logic        eff_clear_s;
  logic [10:0] count_inc_s;

  assign tick_acc_s   = en & frame_tick;
  // A request arriving with the tick counts as already pending at that tick.
  assign eff_reinit_s = init_pend_q | reinit_req;
  assign eff_clear_s  = clr_pend_q | clear_req;
  // Only NORMAL can reach the top of the counter; it holds there.
  assign count_inc_s  = (count_q == COUNT_MAX) ? COUNT_MAX : (count_q + 11'd1);

  // Next-state, counter, pulse and pending-flag computation.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    commit_d    = 1'b0;
    done_d      = 1'b0;
    // Requests accumulate in every cycle, including while en=0.
    clr_pend_d  = eff_clear_s;
    init_pend_d = eff_reinit_s;

    if (tick_acc_s) begin
      commit_d = 1'b1;
      if (eff_reinit_s) begin
        // Re-init wins in every state. INIT wipes the panel, so any pending
        // clear is dropped and an in-flight clear ends without clear_done.
        state_d     = ST_INIT;
        count_d     = 11'd0;
        init_pend_d = 1'b0;
        clr_pend_d  = 1'b0;
      end else begin
        case (state_q)
          ST_INIT: begin
            // Clear requests are meaningless while the init waveform runs.
            clr_pend_d = 1'b0;
            if (count_q == INIT_LAST) begin
              state_d = ST_NORMAL;
              count_d = 11'd0;
            end else begin
              count_d = count_inc_s;
            end
          end
          ST_NORMAL: begin
            if (eff_clear_s) begin
              state_d    = ST_CLEAR;
              count_d    = 11'd0;
              clr_pend_d = 1'b0;
            end else begin
              count_d = count_inc_s;
            end
          end
          ST_CLEAR: begin
            // A clear_req seen here stays pending and starts a second clear
            // on the first tick spent back in NORMAL.
            if (count_q == CLEAR_LAST) begin
              state_d = ST_NORMAL;
              count_d = 11'd0;
              done_d  = 1'b1;
            end else begin
              count_d = count_inc_s;
            end
          end
          default: begin
            // Illegal encoding: fall back to a full init.
            state_d    = ST_INIT;
            count_d    = 11'd0;
            clr_pend_d = 1'b0;
          end
        endcase
      end
    end else begin
      // No accepted tick: state and counter hold, no pulses.
      state_d  = state_q;
      count_d  = count_q;
    end
  end

  // State, counter, output pulses and pending flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      count_q     <= 11'd0;
      commit_q    <= 1'b0;
      done_q      <= 1'b0;
      clr_pend_q  <= 1'b0;
      init_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      commit_q    <= commit_d;
      done_q      <= done_d;
      clr_pend_q  <= clr_pend_d;
      init_pend_q <= init_pend_d;
    end
  end

  assign op_state      = state_q;
  assign op_framecount = count_q;
  assign op_commit     = commit_q;
  assign clear_done    = done_q;
  assign busy          = (state_q != ST_NORMAL) | clr_pend_q | init_pend_q;

  op_state_sequencer_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .frame_tick (frame_tick),
    .op_state   (op_state),
    .op_commit  (op_commit),
    .clear_done (clear_done)
  );

endmodule

// ---------------------------------------------------------------------------
// op_state_sequencer_chk
//
// Purpose:
//   Protocol properties of the sequencer outputs.
//
// Ports (all inputs): clk, rst_n, en, frame_tick, op_state, op_commit,
//   clear_done -- taps of the sequencer interface.
// ---------------------------------------------------------------------------
module op_state_sequencer_chk (
  input logic       clk,
  input logic       rst_n,
  input logic       en,
  input logic       frame_tick,
  input logic [1:0] op_state,
  input logic       op_commit,
  input logic       clear_done
);

  a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
    op_state != 2'd3);

  a_done_with_commit: assert property (@(posedge clk) disable iff (!rst_n)
    clear_done |-> op_commit);

  a_done_in_normal: assert property (@(posedge clk) disable iff (!rst_n)
    clear_done |-> (op_state == 2'd1));

  a_commit_after_tick: assert property (@(posedge clk) disable iff (!rst_n)
    op_commit == $past(en & frame_tick));

  a_state_change_commits: assert property (@(posedge clk) disable iff (!rst_n)
    (op_state != $past(op_state)) |-> op_commit);

endmodule

// File: tb/tb_op_state_sequencer.sv
// ---------------------------------------------------------------------------
// tb_op_state_sequencer
//
// Purpose:
//   Self-checking bench for op_state_sequencer with default parameters.
//   Inputs are driven on the falling edge, outputs sampled on the next
//   falling edge. A frame-level reference model runs alongside every cycle;
//   a short vector table, directed scenarios and a random run follow.
// ---------------------------------------------------------------------------
module tb_op_state_sequencer;

  localparam int INIT_N  = 340;
  localparam int CLEAR_N = 120;
  localparam int SAT     = 2047;
  localparam int S_INIT  = 0;
  localparam int S_NORM  = 1;
  localparam int S_CLR   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        frame_tick = 1'b0;
  logic        clear_req = 1'b0;
  logic        reinit_req = 1'b0;
  logic [1:0]  op_state;
  logic [10:0] op_framecount;
  logic        op_commit;
  logic        clear_done;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

  // Reference model: which phase we are in, frames spent in it, requests held.
  int m_state;
  int m_count;
  bit m_cpend;
  bit m_ipend;
  bit m_commit;
  bit m_done;

  always #5 clk = ~clk;

  op_state_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en            (en),
    .frame_tick    (frame_tick),
    .clear_req     (clear_req),
    .reinit_req    (reinit_req),
    .op_state      (op_state),
    .op_framecount (op_framecount),
    .op_commit     (op_commit),
    .clear_done    (clear_done),
    .busy          (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Length of a finite phase in frames; NORMAL lasts until a request.
  function automatic int phase_len(input int s);
    if (s == S_INIT) return INIT_N;
    if (s == S_CLR)  return CLEAR_N;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = S_INIT; m_count = 0; m_cpend = 1'b0; m_ipend = 1'b0;
    m_commit = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit t, input bit c, input bit r);
    int prev;
    prev     = m_state;
    m_ipend  = m_ipend | r;
    m_cpend  = m_cpend | c;
    m_commit = e & t;
    m_done   = 1'b0;
    if (e & t) begin
      if (m_ipend) begin
        m_state = S_INIT; m_count = 0; m_ipend = 1'b0; m_cpend = 1'b0;
      end else if (m_state == S_NORM && m_cpend) begin
        m_state = S_CLR; m_count = 0; m_cpend = 1'b0;
      end else if (phase_len(m_state) != 0 && m_count + 1 == phase_len(m_state)) begin
        m_done  = (m_state == S_CLR);
        m_state = S_NORM; m_count = 0;
      end else begin
        m_count = (m_count + 1 > SAT) ? SAT : m_count + 1;
      end
      if (prev == S_INIT) m_cpend = 1'b0;
    end
  endtask

  task automatic cmp_model();
    check("model_state",  32'(op_state),      m_state);
    check("model_count",  32'(op_framecount), m_count);
    check("model_commit", 32'(op_commit),     32'(m_commit));
    check("model_done",   32'(clear_done),    32'(m_done));
    check("model_busy",   32'(busy),          32'(m_state != S_NORM || m_cpend || m_ipend));
  endtask

  // One clock: drive at falling edge, model at rising edge, compare at next fall.
  task automatic step(input bit e, input bit t, input bit c, input bit r);
    en = e; frame_tick = t; clear_req = c; reinit_req = r;
    @(posedge clk);
    model_step(e, t, c, r);
    @(negedge clk);
    frame_tick = 1'b0; clear_req = 1'b0; reinit_req = 1'b0;
    cmp_model();
    if (clear_done === 1'b1) done_seen++;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Assert reset between clock edges and check the outputs respond at once.
  task automatic do_reset();
    #2;
    rst_n = 1'b0; en = 1'b0; frame_tick = 1'b0; clear_req = 1'b0; reinit_req = 1'b0;
    #1;
    model_reset();
    check("rst_state",  32'(op_state),      32'd0);
    check("rst_count",  32'(op_framecount), 32'd0);
    check("rst_commit", 32'(op_commit),     32'd0);
    check("rst_done",   32'(clear_done),    32'd0);
    check("rst_busy",   32'(busy),          32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_sc(input string name, input int st, input int cnt);
    check({name, "_state"}, 32'(op_state), st);
    check({name, "_count"}, 32'(op_framecount), cnt);
  endtask

  typedef struct {
    bit e; bit t; bit c; bit r;
    int st; int cnt; bit cm; bit dn; bit bz;
  } vec_t;

  vec_t tbl[12];
  int   dsnap;
  int   commits;

  initial begin
    // Vectors applied from reset; each row is inputs then outputs one clock later.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 1'b1, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 2, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 0, 1, 1'b0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 0, 2, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b1};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(tbl[i].e, tbl[i].t, tbl[i].c, tbl[i].r);
      check($sformatf("vec%0d_state", i),  32'(op_state),      tbl[i].st);
      check($sformatf("vec%0d_count", i),  32'(op_framecount), tbl[i].cnt);
      check($sformatf("vec%0d_commit", i), 32'(op_commit),     32'(tbl[i].cm));
      check($sformatf("vec%0d_done", i),   32'(clear_done),    32'(tbl[i].dn));
      check($sformatf("vec%0d_busy", i),   32'(busy),          32'(tbl[i].bz));
    end

    // Full init waveform from reset.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_sc("init_idle", S_INIT, 0);
    for (int k = 1; k <= INIT_N; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (k < INIT_N) expect_sc("init_run", S_INIT, k);
    end
    expect_sc("init_exit", S_NORM, 0);
    check("init_exit_busy", 32'(busy), 32'd0);

    // Clear requested on the same cycle as a tick.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    expect_sc("clr_start", S_CLR, 0);
    dsnap = done_seen;
    ticks(CLEAR_N - 1);
    expect_sc("clr_last", S_CLR, CLEAR_N - 1);
    ticks(1);
    expect_sc("clr_end", S_NORM, 0);
    check("clr_end_done", 32'(clear_done), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("clr_done_width", 32'(clear_done), 32'd0);
    check("clr_done_count", done_seen - dsnap, 32'd1);

    // Second clear requested mid-clear.
    dsnap = done_seen;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(50);
    expect_sc("dbl_f50", S_CLR, 50);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    ticks(CLEAR_N - 50);
    expect_sc("dbl_first_end", S_NORM, 0);
    check("dbl_pending_busy", 32'(busy), 32'd1);
    ticks(1);
    expect_sc("dbl_second_start", S_CLR, 0);
    ticks(CLEAR_N);
    expect_sc("dbl_second_end", S_NORM, 0);
    check("dbl_done_count", done_seen - dsnap, 32'd2);

    // Re-init aborts a clear.
    dsnap = done_seen;
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(10);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    ticks(1);
    expect_sc("abort_init", S_INIT, 0);
    ticks(INIT_N);
    expect_sc("abort_normal", S_NORM, 0);
    check("abort_no_pend", 32'(busy), 32'd0);
    check("abort_no_done", done_seen - dsnap, 32'd0);

    // Freeze during INIT with a clear request that INIT discards.
    do_reset();
    ticks(100);
    commits = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b1, (i == 5), 1'b0);
      if (op_commit === 1'b1) commits++;
    end
    expect_sc("frz_hold", S_INIT, 100);
    check("frz_no_commit", commits, 32'd0);
    ticks(INIT_N - 101);
    expect_sc("frz_last", S_INIT, INIT_N - 1);
    ticks(1);
    expect_sc("frz_normal", S_NORM, 0);
    check("frz_clear_dropped", 32'(busy), 32'd0);
    ticks(1);
    expect_sc("frz_stay", S_NORM, 1);

    // Saturation in NORMAL.
    commits = 0;
    for (int i = 0; i < 2100; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (op_commit === 1'b1) commits++;
    end
    expect_sc("sat", S_NORM, SAT);
    check("sat_commits", commits, 32'd2100);

    // Reset in the middle of a clear.
    step(1'b1, 1'b1, 1'b1, 1'b0);
    ticks(30);
    dsnap = done_seen;
    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expect_sc("rst_mid_hold", S_INIT, 0);
    ticks(1);
    expect_sc("rst_mid_restart", S_INIT, 1);
    check("rst_mid_no_done", done_seen - dsnap, 32'd0);

    // Random traffic against the model, with one asynchronous reset.
    do_reset();
    for (int i = 0; i < 8000; i++) begin
      if (i == 4000) do_reset();
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 39) == 0), ($urandom_range(0, 2999) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/op_state_sequencer.md
OP_STATE_SEQUENCER -- requirements
Module: op_state_sequencer

Interface
REQ-001 SHALL have parameter INIT_FRAMES, default 11'd340: frame length of the power-up init waveform.
REQ-002 SHALL have parameter CLEAR_FRAMES, default 11'd120: frame length of an in-place screen clear.
REQ-003 SHALL have port clk  input  1  system clock; all sequential logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port en  input  1  sequencer enable; 0 freezes all state.
REQ-006 SHALL have port frame_tick  input  1  one-cycle pulse at each frame boundary from the timing generator.
REQ-007 SHALL have port clear_req  input  1  one-cycle pulse requesting an in-place clear.
REQ-008 SHALL have port reinit_req  input  1  one-cycle pulse requesting a full re-init.
REQ-009 SHALL have port op_state  output  2  0=INIT, 1=NORMAL, 2=CLEAR_NORMAL; value 3 is never driven.
REQ-010 SHALL have port op_framecount  output  11  frame index within the current state.
REQ-011 SHALL have port op_commit  output  1  one-cycle pulse when op_state/op_framecount update.
REQ-012 SHALL have port clear_done  output  1  one-cycle pulse when a clear finishes.
REQ-013 SHALL have port busy  output  1  high when op_state != NORMAL or any request is pending.

Function
REQ-014 SHALL register every output; op_state and op_framecount SHALL change only in the cycle after an accepted tick (frame_tick=1 and en=1), so both stay stable for a whole frame.
REQ-015 SHALL latch clear_req into clr_pend and reinit_req into init_pend in any cycle, including while en=0; a pending flag SHALL clear only when it is consumed.
REQ-016 SHALL treat a request arriving in the same cycle as an accepted tick as already pending at that tick (effective = pend | req).
REQ-017 INIT on tick: if effective reinit, count SHALL restart at 0 and init_pend SHALL clear; else if count == INIT_FRAMES-1, go to NORMAL with count 0; else count+1.
REQ-018 SHALL discard clr_pend (and any same-cycle clear_req) when the sequencer enters or restarts INIT; INIT clears the panel, so no clear_done is issued for it.
REQ-019 NORMAL on tick, priority order: (1) effective reinit -> INIT, count 0, consume init_pend; (2) effective clear -> CLEAR_NORMAL, count 0, consume clr_pend; (3) otherwise count+1, saturating at 11'd2047.
REQ-020 CLEAR_NORMAL on tick: if effective reinit -> INIT, count 0 (abort, no clear_done); else if count == CLEAR_FRAMES-1 -> NORMAL, count 0, clear_done pulse; else count+1.
REQ-021 SHALL leave a clear_req received during CLEAR_NORMAL pending, so it starts a second clear one tick after the return to NORMAL.
REQ-022 SHALL assert clear_done and op_commit together for exactly one cycle, in the same cycle that the new op_state is presented.
REQ-023 SHALL assert op_commit for one cycle after every accepted tick, including self-loops and saturated counts.
REQ-024 SHALL ignore frame_tick when en=0: no count change, no transition, no pulses.
REQ-025 SHALL compute busy combinationally from the registered state and the pending flags.
REQ-026 SHALL treat a frame_tick held high for several cycles as one accepted tick per cycle; the upstream generator guarantees single-cycle pulses.
REQ-027 SHALL require INIT_FRAMES and CLEAR_FRAMES to be in the range 1..2047; a value of 1 gives a single-frame state.

Reset
REQ-028 When rst_n=0, SHALL asynchronously force op_state=INIT, op_framecount=0, op_commit=0, clear_done=0, clr_pend=0 and init_pend=0; busy therefore reads 1.
REQ-029 A reset asserted mid-INIT or mid-clear SHALL abort the operation without a clear_done pulse, and the sequence SHALL restart at INIT frame 0 after release.
REQ-030 After rst_n deasserts, the first transition SHALL occur only on the first accepted tick.

Verification
REQ-031 Reset release, en=1, 340 ticks -> op_framecount 0..339 in INIT, then NORMAL/0 after tick 340, busy falls on that cycle.
REQ-032 In NORMAL, clear_req and frame_tick in the same cycle -> next cycle CLEAR_NORMAL/0; after 120 further ticks -> NORMAL/0 with a single-cycle clear_done.
REQ-033 clear_req at CLEAR frame 50 -> first clear completes, one tick in NORMAL, second clear starts, and two clear_done pulses occur in total.
REQ-034 reinit_req at CLEAR frame 10 -> INIT/0 on the next tick, with no clear_done and clr_pend empty.
REQ-035 en=0 for 20 ticks at INIT frame 100, with clear_req pulsed -> count stays at 100; after en=1, INIT continues to 339 and the clear request is discarded.
REQ-036 NORMAL held for 2100 ticks -> op_framecount saturates at 2047 and op_commit still pulses on every tick.
